// File: rtl/alu_result_packer_if.sv
// Bundle between the ALU unit outputs, the packer and the UART transmitter.
// The packer takes the slave side; the unit/UART environment takes the master side.
interface alu_result_packer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] arith_out;
    logic             carry_out;
    logic             arith_flag;
    logic [WIDTH-1:0] logic_out;
    logic             logic_flag;
    logic [WIDTH-1:0] cmp_out;
    logic             cmp_flag;
    logic [WIDTH-1:0] shift_out;
    logic             shift_flag;
    logic             tx_busy;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             packer_busy;
    logic             overrun;

    modport master (
        output arith_out, carry_out, arith_flag, logic_out, logic_flag,
               cmp_out, cmp_flag, shift_out, shift_flag, tx_busy,
        input  tx_data, tx_valid, packer_busy, overrun
    );

    modport slave (
        input  arith_out, carry_out, arith_flag, logic_out, logic_flag,
               cmp_out, cmp_flag, shift_out, shift_flag, tx_busy,
        output tx_data, tx_valid, packer_busy, overrun
    );
endinterface

// File: rtl/alu_result_packer.sv
// Captures one ALU unit result at a time and serialises it to the UART as
// NBYTES result bytes (LSB first) followed by a status byte.
module alu_result_packer #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_packer_if.slave bus
);
    localparam int NBYTES = WIDTH / 8;
    localparam int IW     = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t                  state, state_d;
    logic [IW-1:0]           idx, idx_d;
    logic [WIDTH-1:0]        res_q;
    logic                    carry_q, coll_q;
    logic [1:0]              unit_q;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q;
    logic                    capture;

    logic [3:0]              flags;
    logic [3:0][WIDTH-1:0]   res_vec;
    logic [1:0]              unit_sel;
    logic                    any_flag, coll;
    logic [NBYTES:0][7:0]    frame;

    // Index in flags/res_vec is the unit code, so lowest set bit wins priority.
    assign flags    = {bus.shift_flag, bus.cmp_flag, bus.logic_flag, bus.arith_flag};
    assign res_vec  = {bus.shift_out, bus.cmp_out, bus.logic_out, bus.arith_out};
    assign any_flag = |flags;
    assign coll     = (flags & (flags - 4'd1)) != 4'd0;

    always_comb begin
        unit_sel = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (flags[i]) unit_sel = 2'(i);
    end

    assign frame = {{carry_q, coll_q, 4'b0000, unit_q}, res_q};

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        capture    = 1'b0;
        case (state)
            IDLE: if (any_flag) begin
                capture = 1'b1;
                idx_d   = '0;
                busy_d  = 1'b1;
                state_d = SEND;
            end
            SEND: if (!bus.tx_busy) begin
                tx_valid_d = 1'b1;
                tx_data_d  = frame[idx];
                state_d    = WAIT_ACK;
            end
            WAIT_ACK: if (bus.tx_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!bus.tx_busy) begin
                if (idx < IW'(NBYTES)) begin
                    idx_d   = idx + IW'(1);
                    state_d = SEND;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            coll_q     <= 1'b0;
            unit_q     <= 2'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            idx        <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            // A result arriving while any frame state is active is dropped.
            overrun_q  <= any_flag && (state != IDLE);
            if (capture) begin
                res_q   <= res_vec[unit_sel];
                carry_q <= bus.carry_out & bus.arith_flag;
                coll_q  <= coll;
                unit_q  <= unit_sel;
            end
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.packer_busy = busy_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_alu_result_packer.sv
// Bench for alu_result_packer: vector table, hand sequences for overrun and
// stall/reset, and randomized results checked against a frame-level model.
module tb_alu_result_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_result_packer_if #(.WIDTH(16)) u();
    alu_result_packer #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(u.slave));

    typedef struct {
        logic [3:0]      flags;
        logic [15:0]     a, l, c, s;
        logic            cy;
        int              blen;
        logic [2:0][7:0] exp;
    } vec_t;

    int   total = 0, bad = 0;
    int   busy_len = 10, bcnt = 0, viol = 0, ovr_cnt = 0;
    bit   stall = 1'b0, prev_v = 1'b0, txb = 1'b0;
    logic [7:0] rxq[$];

    assign u.tx_busy = txb;

    // UART model: busy for busy_len cycles per byte, held high while stall is set.
    always @(posedge clk) begin
        if (u.tx_valid) begin
            rxq.push_back(u.tx_data);
            if (txb || prev_v) viol++;
            txb  <= 1'b1;
            bcnt = busy_len;
        end else if (bcnt > 0) begin
            bcnt = bcnt - 1;
            if (bcnt == 0) txb <= stall;
        end else begin
            txb <= stall;
        end
        prev_v = u.tx_valid;
        if (u.overrun) ovr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] f, input logic [15:0] a, l, c, s, input logic cy);
        u.arith_out = a; u.logic_out = l; u.cmp_out = c; u.shift_out = s;
        u.carry_out = cy;
        {u.shift_flag, u.cmp_flag, u.logic_flag, u.arith_flag} = f;
    endtask

    task automatic pulse(input logic [3:0] f, input logic [15:0] a, l, c, s, input logic cy);
        @(negedge clk);
        drive(f, a, l, c, s, cy);
        @(negedge clk);
        {u.shift_flag, u.cmp_flag, u.logic_flag, u.arith_flag} = 4'b0000;
    endtask

    task automatic wait_bytes(input int n, input string nm);
        int k = 0;
        while (rxq.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (rxq.size() < n) chk({nm, "_timeout"}, 32'(rxq.size()), 32'(n));
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (u.packer_busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (u.packer_busy) chk({nm, "_idle_timeout"}, 32'(u.packer_busy), 0);
    endtask

    task automatic check_frame(input string nm, input logic [2:0][7:0] e);
        chk({nm, "_len"}, 32'(rxq.size()), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s_b%0d", nm, i),
                (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD, 32'(e[i]));
    endtask

    // Frame-level reference: pick the winning unit, then lay out bytes LSB first.
    function automatic logic [2:0][7:0] ref_frame(input logic [3:0] f,
                                                  input logic [15:0] a, l, c, s,
                                                  input logic cy);
        logic [15:0] r;
        logic [1:0]  un;
        logic [7:0]  st;
        if (f[0])      begin r = a; un = 2'd0; end
        else if (f[1]) begin r = l; un = 2'd1; end
        else if (f[2]) begin r = c; un = 2'd2; end
        else           begin r = s; un = 2'd3; end
        st = {f[0] & cy, $countones(f) > 1, 4'b0000, un};
        return {st, r[15:8], r[7:0]};
    endfunction

    vec_t tbl[8];

    initial begin
        logic [3:0]  f;
        logic [15:0] ra, rl, rc, rs;
        logic        rcy;
        int          inj;
        bit          sawv;
        int          k;

        tbl[0] = '{4'b0001, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 1'b1, 10, {8'h80, 8'hBE, 8'hEF}};
        tbl[1] = '{4'b1000, 16'h0000, 16'h0000, 16'h0000, 16'h0102, 1'b0, 10, {8'h03, 8'h01, 8'h02}};
        tbl[2] = '{4'b0011, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 10, {8'h40, 8'h12, 8'h34}};
        tbl[3] = '{4'b0010, 16'h0000, 16'hA5A5, 16'h0000, 16'h0000, 1'b1, 1,  {8'h01, 8'hA5, 8'hA5}};
        tbl[4] = '{4'b0100, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 1'b0, 3,  {8'h02, 8'h00, 8'h02}};
        tbl[5] = '{4'b1111, 16'h00FF, 16'h1111, 16'h2222, 16'h3333, 1'b1, 2,  {8'hC0, 8'h00, 8'hFF}};
        tbl[6] = '{4'b1100, 16'h0000, 16'h0000, 16'hABCD, 16'h1111, 1'b1, 4,  {8'h42, 8'hAB, 8'hCD}};
        tbl[7] = '{4'b0110, 16'h0000, 16'h8001, 16'h7777, 16'h0000, 1'b1, 5,  {8'h41, 8'h80, 8'h01}};

        // Reset held with flags toggling.
        rst = 1'b1;
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            #1;
            chk("reset_outputs", {u.tx_data, u.tx_valid, u.packer_busy, u.overrun}, 0);
        end
        @(negedge clk);
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_no_tx", 32'(rxq.size()), 0);
        chk("idle_no_overrun", 32'(ovr_cnt), 0);

        // Vector table.
        for (int t = 0; t < 8; t++) begin
            rxq.delete();
            ovr_cnt  = 0;
            busy_len = tbl[t].blen;
            pulse(tbl[t].flags, tbl[t].a, tbl[t].l, tbl[t].c, tbl[t].s, tbl[t].cy);
            chk($sformatf("v%0d_busy_rise", t), 32'(u.packer_busy), 1);
            chk($sformatf("v%0d_no_early_valid", t), 32'(u.tx_valid), 0);
            @(negedge clk);
            chk($sformatf("v%0d_valid_latency", t), 32'(u.tx_valid), 1);
            chk($sformatf("v%0d_byte0_data", t), 32'(u.tx_data), 32'(tbl[t].exp[0]));
            @(negedge clk);
            chk($sformatf("v%0d_valid_1wide", t), 32'(u.tx_valid), 0);
            wait_bytes(3, $sformatf("v%0d", t));
            wait_idle($sformatf("v%0d", t));
            repeat (5) @(negedge clk);
            check_frame($sformatf("v%0d", t), tbl[t].exp);
            chk($sformatf("v%0d_overrun", t), 32'(ovr_cnt), 0);
        end

        // Overrun while byte1 is in flight.
        rxq.delete(); ovr_cnt = 0; busy_len = 4;
        pulse(4'b0100, 16'h0, 16'h0, 16'h0002, 16'h0, 1'b0);
        wait_bytes(2, "ovr1");
        pulse(4'b0010, 16'h0, 16'h9999, 16'h0002, 16'h0, 1'b0);
        wait_bytes(3, "ovr1");
        wait_idle("ovr1");
        repeat (15) @(negedge clk);
        check_frame("ovr1", {8'h02, 8'h00, 8'h02});
        chk("ovr1_count", 32'(ovr_cnt), 1);

        // Overrun on the cycle the packer returns to idle.
        rxq.delete(); ovr_cnt = 0; busy_len = 4;
        pulse(4'b0100, 16'h0, 16'h0, 16'h0002, 16'h0, 1'b0);
        wait_bytes(3, "ovr2");
        k = 0;
        while (txb && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ovr2_busy_before_return", 32'(u.packer_busy), 1);
        drive(4'b0010, 16'h0, 16'h9999, 16'h0002, 16'h0, 1'b0);
        @(negedge clk);
        {u.shift_flag, u.cmp_flag, u.logic_flag, u.arith_flag} = 4'b0000;
        chk("ovr2_busy_dropped", 32'(u.packer_busy), 0);
        repeat (15) @(negedge clk);
        check_frame("ovr2", {8'h02, 8'h00, 8'h02});
        chk("ovr2_count", 32'(ovr_cnt), 1);

        // Stall with tx_busy held, then asynchronous reset mid-frame.
        rxq.delete(); ovr_cnt = 0; busy_len = 6;
        @(negedge clk);
        stall = 1'b1;
        pulse(4'b0010, 16'h0, 16'h3C5A, 16'h0, 16'h0, 1'b0);
        sawv = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (u.tx_valid) sawv = 1'b1;
        end
        chk("stall_no_valid", 32'(sawv), 0);
        chk("stall_busy_held", 32'(u.packer_busy), 1);
        stall = 1'b0;
        wait_bytes(1, "stall");
        chk("stall_byte0", (rxq.size() > 0) ? 32'(rxq[0]) : 32'hDEAD, 32'h5A);
        k = 0;
        while (txb && k < 100) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {u.tx_data, u.tx_valid, u.packer_busy, u.overrun}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("no_resume_bytes", 32'(rxq.size()), 1);
        chk("no_resume_busy", 32'(u.packer_busy), 0);
        rxq.delete();
        pulse(4'b0010, 16'h0, 16'hA5A5, 16'h0, 16'h0, 1'b0);
        wait_bytes(3, "fresh");
        wait_idle("fresh");
        repeat (5) @(negedge clk);
        check_frame("fresh", {8'h01, 8'hA5, 8'hA5});

        // Randomized results, optionally with a dropped result mid-frame.
        for (int n = 0; n < 30; n++) begin
            rxq.delete(); ovr_cnt = 0;
            busy_len = int'($urandom_range(1, 6));
            f   = 4'($urandom_range(1, 15));
            ra  = 16'($urandom); rl = 16'($urandom);
            rc  = 16'($urandom); rs = 16'($urandom);
            rcy = 1'($urandom);
            inj = int'($urandom_range(0, 1));
            pulse(f, ra, rl, rc, rs, rcy);
            wait_bytes(1, $sformatf("r%0d", n));
            if (inj == 1)
                pulse(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom), 1'($urandom));
            wait_bytes(3, $sformatf("r%0d", n));
            wait_idle($sformatf("r%0d", n));
            repeat (3) @(negedge clk);
            check_frame($sformatf("r%0d", n), ref_frame(f, ra, rl, rc, rs, rcy));
            chk($sformatf("r%0d_overrun", n), 32'(ovr_cnt), 32'(inj));
        end

        chk("tx_protocol", 32'(viol), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
